// File: rtl/vmicro16_apb_shared_mem_pkg.sv
// Shared types and cluster-level constants for the shared data-memory APB slave.
// Bus widths and the default semaphore base mirror the SoC configuration.
package vmicro16_apb_shared_mem_pkg;

   localparam int APB_WIDTH        = 16;
   localparam int DATA_WIDTH       = 16;
   localparam int SEM_BASE_DEFAULT = 'h0F00;
   localparam int WAIT_CNT_W       = 4;
   localparam int WAIT_MAX         = (1 << WAIT_CNT_W) - 1;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   typedef enum logic [1:0] {
      REG_MEM = 2'd0,
      REG_SEM = 2'd1,
      REG_ERR = 2'd2
   } region_t;

   function automatic region_t decode_addr(input int addr, input int depth,
                                           input int sem_base, input int nsem);
      if (addr < depth)
         return REG_MEM;
      if (addr >= sem_base && addr < sem_base + nsem)
         return REG_SEM;
      return REG_ERR;
   endfunction

endpackage

// File: rtl/vmicro16_bram.sv
// Single-port word RAM with synchronous read; read data holds until the next read enable.
module vmicro16_bram #(
   parameter int DEPTH = 256,
   parameter int WIDTH = 16,
   parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             we_i,
   input  logic             re_i,
   input  logic [AW-1:0]    addr_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic [WIDTH-1:0] rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we_i)
         mem_q[addr_i] <= wdata_i;
      if (re_i)
         rdata_q <= mem_q[addr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/vmicro16_apb_shared_mem.sv
// Shared data-memory APB slave: BRAM words, test-and-set semaphores, programmable wait states.
// Setup in cycle T, PREADY in T+1+WAIT_STATES; dropping PSELx while busy aborts with no side effects.
module vmicro16_apb_shared_mem
   import vmicro16_apb_shared_mem_pkg::*;
#(
   parameter int BUS_WIDTH   = APB_WIDTH,
   parameter int DATA_WIDTH  = vmicro16_apb_shared_mem_pkg::DATA_WIDTH,
   parameter int MEM_DEPTH   = 256,
   parameter int NSEM        = 8,
   parameter int SEM_BASE    = SEM_BASE_DEFAULT,
   parameter int WAIT_STATES = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [BUS_WIDTH-1:0]  S_PADDR,
   input  logic                  S_PWRITE,
   input  logic                  S_PSELx,
   input  logic                  S_PENABLE,
   input  logic [DATA_WIDTH-1:0] S_PWDATA,
   output logic [DATA_WIDTH-1:0] S_PRDATA,
   output logic                  S_PREADY,
   output logic [NSEM-1:0]       sem_state,
   output logic                  err
);

   localparam int MEM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam int SEM_AW = (NSEM > 1) ? $clog2(NSEM) : 1;
   localparam logic [WAIT_CNT_W-1:0] WAIT_INIT = WAIT_CNT_W'(WAIT_STATES);

   // The wait counter is only 4 bits wide, so larger settings are rejected at elaboration.
   if (WAIT_STATES > WAIT_MAX || WAIT_STATES < 0) begin : g_bad_wait
      $error("WAIT_STATES out of range");
   end

   state_t                  state_q, state_d;
   logic [BUS_WIDTH-1:0]    addr_q, addr_d;
   logic                    write_q, write_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
   logic [NSEM-1:0]         sem_q, sem_d;
   logic [DATA_WIDTH-1:0]   prdata_q, prdata_d;

   logic                    setup;
   logic                    pready;
   region_t                 region;
   logic [31:0]             sem_off;
   logic [SEM_AW-1:0]       sem_idx;
   logic [DATA_WIDTH-1:0]   rd_mux;
   logic                    bram_we;
   logic [MEM_AW-1:0]       bram_addr;
   logic [DATA_WIDTH-1:0]   bram_rdata;

   assign setup  = (state_q == ST_IDLE) && S_PSELx && !S_PENABLE;
   assign pready = (state_q == ST_BUSY) && (cnt_q == '0) && S_PSELx && S_PENABLE;

   always_comb begin
      region  = decode_addr(32'(addr_q), MEM_DEPTH, SEM_BASE, NSEM);
      sem_off = 32'(addr_q) - 32'(SEM_BASE);
      sem_idx = sem_off[SEM_AW-1:0];
      rd_mux  = '0;
      case (region)
         REG_MEM: rd_mux = bram_rdata;
         REG_SEM: rd_mux = {{(DATA_WIDTH-1){1'b0}}, sem_q[sem_idx]};
         default: rd_mux = '0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      write_d = write_q;
      wdata_d = wdata_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (setup) begin
               addr_d  = S_PADDR;
               write_d = S_PWRITE;
               wdata_d = S_PWDATA;
               cnt_d   = WAIT_INIT;
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (!S_PSELx)
               state_d = ST_IDLE;
            else if (cnt_q != '0)
               cnt_d = cnt_q - WAIT_CNT_W'(1);
            else if (S_PENABLE)
               state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Only one access is ever in flight, so read-then-set here is atomic across cores.
   always_comb begin
      sem_d    = sem_q;
      prdata_d = prdata_q;
      if (pready) begin
         prdata_d = rd_mux;
         if (region == REG_SEM) begin
            if (write_q)
               sem_d[sem_idx] = wdata_q[0];
            else
               sem_d[sem_idx] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         addr_q   <= '0;
         write_q  <= 1'b0;
         wdata_q  <= '0;
         cnt_q    <= '0;
         sem_q    <= '0;
         prdata_q <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         write_q  <= write_d;
         wdata_q  <= wdata_d;
         cnt_q    <= cnt_d;
         sem_q    <= sem_d;
         prdata_q <= prdata_d;
      end
   end

   // The RAM port reads from the live setup address and writes from the latched one.
   assign bram_we   = pready && write_q && (region == REG_MEM);
   assign bram_addr = pready ? addr_q[MEM_AW-1:0] : S_PADDR[MEM_AW-1:0];

   vmicro16_bram #(
      .DEPTH (MEM_DEPTH),
      .WIDTH (DATA_WIDTH),
      .AW    (MEM_AW)
   ) u_bram (
      .clk     (clk),
      .we_i    (bram_we),
      .re_i    (setup),
      .addr_i  (bram_addr),
      .wdata_i (wdata_q),
      .rdata_o (bram_rdata)
   );

   assign S_PREADY  = pready;
   assign S_PRDATA  = pready ? rd_mux : prdata_q;
   assign err       = pready && (region == REG_ERR);
   assign sem_state = sem_q;

endmodule
